// File: rtl/game_pkg.sv
// Shared game constants and types: motion FSM encoding, object size and
// saturating 12-bit arithmetic helpers.
package game_pkg;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } motion_state_e;

    localparam logic [11:0] OBJ_SIZE = 12'd40;

    function automatic logic [11:0] sat_sub(input logic [11:0] a, input logic [11:0] b);
        return (a < b) ? 12'd0 : a - b;
    endfunction

    function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [11:0] b,
                                            input logic [11:0] max_val);
        logic [12:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[11:0];
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an asynchronous input; EDGE selects whether the
// output is the synchronized level or a one-cycle rising-edge pulse.
module btn_sync #(
    parameter bit EDGE = 1'b0
) (
    input  logic clk_vga,
    input  logic rst_n,
    input  logic din,
    output logic out
);

    logic meta_q, sync_q, prev_q;
    logic meta_d, sync_d, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign out = EDGE ? (sync_q & ~prev_q) : sync_q;

endmodule

// File: rtl/obj_motion.sv
// Per-frame object motion: horizontal stepping with edge clamping and a
// ground/rise/fall jump FSM, all advanced once per vertical-sync tick.
module obj_motion
    import game_pkg::*;
#(
    parameter logic [11:0] X_INIT   = 12'd300,
    parameter logic [11:0] GROUND_Y = 12'd400,
    parameter logic [11:0] X_MAX    = 12'd640 - OBJ_SIZE,
    parameter logic [11:0] STEP     = 12'd4,
    parameter logic [5:0]  JUMP_V   = 6'd12,
    parameter logic [5:0]  MAX_FALL = 6'd12
) (
    input  logic        clk_vga,
    input  logic        rst_n,
    input  logic        y_valid,
    input  logic        end_show,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    output logic [11:0] obj_x_begin,
    output logic [11:0] obj_y_begin,
    output logic        airborne
);

    logic left_s, right_s, jump_rise, frame_tick;

    btn_sync #(.EDGE(1'b0)) u_left  (.clk_vga(clk_vga), .rst_n(rst_n), .din(btn_left),  .out(left_s));
    btn_sync #(.EDGE(1'b0)) u_right (.clk_vga(clk_vga), .rst_n(rst_n), .din(btn_right), .out(right_s));
    btn_sync #(.EDGE(1'b1)) u_jump  (.clk_vga(clk_vga), .rst_n(rst_n), .din(btn_jump),  .out(jump_rise));
    // Inverting y_valid turns its falling edge (start of sync) into a rising pulse.
    btn_sync #(.EDGE(1'b1)) u_vsync (.clk_vga(clk_vga), .rst_n(rst_n), .din(~y_valid),  .out(frame_tick));

    motion_state_e state_q, state_d;
    logic [11:0]   x_q, x_d, y_q, y_d;
    logic [5:0]    vy_q, vy_d;
    logic          jump_req_q, jump_req_d;
    logic [12:0]   fall_sum;

    assign fall_sum = {1'b0, y_q} + {7'd0, vy_q};

    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        vy_d       = vy_q;
        jump_req_d = (frame_tick || end_show) ? 1'b0 : (jump_req_q | jump_rise);

        if (frame_tick && !end_show) begin
            unique case (state_q)
                ST_GROUND: begin
                    if (jump_req_q) begin
                        y_d     = sat_sub(y_q, {6'd0, JUMP_V});
                        vy_d    = JUMP_V - 6'd1;
                        state_d = ST_RISE;
                    end else begin
                        vy_d = 6'd0;
                    end
                end
                ST_RISE: begin
                    if (vy_q == 6'd0) begin
                        vy_d    = 6'd1;
                        state_d = ST_FALL;
                    end else begin
                        y_d  = sat_sub(y_q, {6'd0, vy_q});
                        vy_d = vy_q - 6'd1;
                    end
                end
                ST_FALL: begin
                    if (fall_sum >= {1'b0, GROUND_Y}) begin
                        y_d     = GROUND_Y;
                        vy_d    = 6'd0;
                        state_d = ST_GROUND;
                    end else begin
                        y_d  = fall_sum[11:0];
                        vy_d = (vy_q >= MAX_FALL) ? MAX_FALL : vy_q + 6'd1;
                    end
                end
                default: state_d = ST_GROUND;
            endcase

            if (left_s && !right_s) begin
                x_d = sat_sub(x_q, STEP);
            end else if (right_s && !left_s) begin
                x_d = sat_add(x_q, STEP, X_MAX);
            end
        end
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_GROUND;
            x_q        <= X_INIT;
            y_q        <= GROUND_Y;
            vy_q       <= 6'd0;
            jump_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            vy_q       <= vy_d;
            jump_req_q <= jump_req_d;
        end
    end

    assign obj_x_begin = x_q;
    assign obj_y_begin = y_q;
    assign airborne    = (state_q != ST_GROUND);

endmodule

// File: doc/obj_motion.md
OBJ_MOTION -- requirements
Module: obj_motion

Interface
REQ-001 SHALL have parameter X_INIT, default 12'd300, meaning object x at reset (pixels, visible-area relative).
REQ-002 SHALL have parameter GROUND_Y, default 12'd400, meaning object y when resting on ground.
REQ-003 SHALL have parameter X_MAX, default 12'd600, meaning largest legal obj_x_begin (640 - 40 object width).
REQ-004 SHALL have parameter STEP, default 12'd4, meaning horizontal pixels moved per frame.
REQ-005 SHALL have parameter JUMP_V, default 6'd12, meaning initial upward speed (pixels/frame).
REQ-006 SHALL have parameter MAX_FALL, default 6'd12, meaning fall-speed saturation.
REQ-007 SHALL have port clk_vga  input  1  pixel clock, 25.175 MHz.
REQ-008 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-009 SHALL have port y_valid  input  1  vertical sync from VGA timing; low during sync pulse.
REQ-010 SHALL have port end_show  input  1  game-over; freezes motion while high.
REQ-011 SHALL have ports btn_left, btn_right, btn_jump  input  1 each  raw asynchronous buttons, active-high.
REQ-012 SHALL have port obj_x_begin  output  12  object left edge, registered.
REQ-013 SHALL have port obj_y_begin  output  12  object top edge, registered.
REQ-014 SHALL have port airborne  output  1  high when state is RISE or FALL.

Function
REQ-015 SHALL pass each button through a 2-flop synchronizer before any use.
REQ-016 SHALL generate frame_tick as a one-cycle pulse on the clock after a synchronized 1->0 transition of y_valid; all position/state updates occur only on frame_tick.
REQ-017 SHALL latch a jump request on a synchronized 0->1 edge of btn_jump; request is cleared on every frame_tick and while end_show is high.
REQ-018 SHALL implement FSM with states GROUND, RISE, FALL and a 6-bit speed register vy.
REQ-019 GROUND, on tick with jump request: y <= y - JUMP_V, vy <= JUMP_V - 1, go RISE; otherwise stay, vy = 0.
REQ-020 RISE, on tick: if vy == 0 go FALL with vy <= 1 and y unchanged; else y <= y - vy, vy <= vy - 1; y saturates at 0.
REQ-021 FALL, on tick: if y + vy >= GROUND_Y then y <= GROUND_Y, vy <= 0, go GROUND; else y <= y + vy, vy <= min(vy + 1, MAX_FALL).
REQ-022 Jump requests arriving in RISE or FALL SHALL be discarded (no double jump).
REQ-023 Horizontal, on tick (any state): left only -> x <= (x < STEP) ? 0 : x - STEP; right only -> x <= min(x + STEP, X_MAX); both or neither -> x unchanged.
REQ-024 All arithmetic SHALL be 12-bit unsigned with explicit saturation; no wrap-around of x or y is permitted.
REQ-025 While end_show is high, x, y, vy and state SHALL hold; frame_tick is ignored.
REQ-026 Outputs SHALL change only on the clock after frame_tick (latency 1 clock from tick), so they are stable for the whole active frame.

Reset
REQ-027 On rst_n low, asynchronously: obj_x_begin = X_INIT, obj_y_begin = GROUND_Y, state = GROUND, vy = 0, airborne = 0, jump request = 0, synchronizers = 0, y_valid edge register = 1.
REQ-028 Reset asserted mid-jump SHALL return to the reset values; no tick is generated on the first y_valid sample after reset release.

Structure
REQ-029 SHALL place FSM state encoding (GROUND=0, RISE=1, FALL=2) and the object size constant (40) in shared package game_pkg.
REQ-030 SHALL instantiate sub-module btn_sync (2-flop synchronizer plus rising-edge pulse), used four times including y_valid falling-edge detection via inversion.

Verification
REQ-031 Reset, no buttons, 3 frames -> x = 300, y = 400, airborne = 0 throughout.
REQ-032 btn_jump pulse mid-frame -> next tick y = 388, then 377, 367, ... apex 322 after 12 ticks, FALL, return to exactly y = 400 and GROUND, airborne low.
REQ-033 btn_right held 200 frames from x = 300 -> x reaches 600 after 75 ticks and stays 600; btn_left held from x = 2 -> x = 0.
REQ-034 btn_left and btn_right both held 5 frames -> x unchanged at 300.
REQ-035 end_show high during RISE at y = 377 for 10 frames -> x, y, state frozen; after deassert motion resumes from y = 377; jump pressed during end_show ignored.
REQ-036 rst_n pulsed low mid-FALL at y = 350 -> outputs immediately 300/400, airborne = 0, no tick on release.
